vec_table_ahb: RTL and testbench

VEC_TABLE_AHB -- requirements
Module: vec_table_ahb

---
 rtl/vec_table_pkg.sv | 27 ++
 rtl/vec_table_bank.sv | 47 ++++
 rtl/vec_table_ahb.sv | 162 ++++++++++++++++
 tb/tb_vec_table_ahb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_table_pkg.sv
// Shared types and constants for the AHB vector table.
// Optional lock register is built only with VEC_TABLE_LOCK_EN.
package vec_table_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      DATA,
      ERR1,
      ERR2
   } state_t;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam int LOCK_BIT  = 0;
   localparam int CLEAR_BIT = 1;

   localparam int NUM_IRQ_MIN = 1;
   localparam int NUM_IRQ_MAX = 240;
   localparam int WAIT_MAX    = 3;

   function automatic bit cfg_ok(input int num_irq, input int wait_states);
      return (num_irq >= NUM_IRQ_MIN) && (num_irq <= NUM_IRQ_MAX) &&
             (wait_states >= 0) && (wait_states <= WAIT_MAX);
   endfunction

endpackage

// File: rtl/vec_table_bank.sv
// Override storage with per-entry valid bits; reads fall back to
// the default vector of an entry until it has been overridden.
module vec_table_bank
   import vec_table_pkg::*;
#(
   parameter int NUM_ENTRIES = 32,
   parameter int IDX_W       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [31:0]              wr_data,
   input  logic                     clr_all,
   input  logic [IDX_W-1:0]         rd_idx,
   input  logic [32*NUM_ENTRIES-1:0] default_vec,
   output logic [31:0]              rd_data
);

   logic [31:0]            ovr [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (clr_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Data needs no reset: valid gates every use of it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ovr[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_data = default_vec[32*rd_idx +: 32];
      if (valid[rd_idx]) begin
         rd_data = ovr[rd_idx];
      end
   end

endmodule

// File: rtl/vec_table_ahb.sv
// AHB-Lite slave exposing the vector table plus a lock register.
// Define VEC_TABLE_LOCK_EN to build the lock and locked-write ERROR.
module vec_table_ahb
   import vec_table_pkg::*;
#(
   parameter int NUM_IRQ     = 16,
   parameter int WAIT_STATES = 0,
   parameter int ADDR_WIDTH  = 12
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic                          hsel,
   input  logic [ADDR_WIDTH-1:0]         haddr,
   input  logic [1:0]                    htrans,
   input  logic [2:0]                    hsize,
   input  logic                          hwrite,
   input  logic [31:0]                   hwdata,
   input  logic                          hreadyin,
   input  logic [32*(16+NUM_IRQ)-1:0]    default_vec,
   output logic [31:0]                   hrdata,
   output logic                          hreadyout,
   output logic                          hresp
);

   localparam int NUM_ENTRIES = 16 + NUM_IRQ;
   localparam int IDX_W       = $clog2(NUM_ENTRIES);

   localparam logic [ADDR_WIDTH-1:0] LOCK_OFFSET =
      {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDR_WIDTH:0] TABLE_END =
      (ADDR_WIDTH+1)'(4 * NUM_ENTRIES);
   localparam logic [1:0] WS_LAST =
      2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam bit CFG_OK = cfg_ok(NUM_IRQ, WAIT_STATES);

   state_t state, state_nx;

   logic             accept;
   logic             is_lock;
   logic             in_table;
   logic             bad;
   logic             lock;
   logic             locked;
   logic             cap_write;
   logic             cap_lock;
   logic [IDX_W-1:0] cap_idx;
   logic [1:0]       wait_cnt;
   logic [31:0]      bank_rd;
   logic             wr_entry;
   logic             wr_lockreg;
   logic             clr_all;
   logic             unused_bits;

   assign unused_bits = htrans[0];

   assign accept = hsel & htrans[1] & hreadyin &
                   (state == IDLE || state == DATA || state == ERR2);

   assign is_lock  = (haddr == LOCK_OFFSET);
   assign in_table = ({1'b0, haddr} < TABLE_END);

   assign wr_lockreg = (state == DATA) & cap_write & cap_lock;
   assign wr_entry   = (state == DATA) & cap_write & ~cap_lock;
   assign clr_all    = wr_lockreg & hwdata[CLEAR_BIT] & ~lock;

`ifdef VEC_TABLE_LOCK_EN
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         lock <= 1'b0;
      end else if (wr_lockreg & hwdata[LOCK_BIT]) begin
         lock <= 1'b1;
      end
   end

   // A lock completing this cycle already guards the next address phase.
   assign locked = lock | (wr_lockreg & hwdata[LOCK_BIT]);
`else
   assign lock   = 1'b0;
   assign locked = 1'b0;
`endif

   assign bad = ~CFG_OK |
                (hsize != HSIZE_WORD) |
                (haddr[1:0] != 2'b00) |
                (~in_table & ~is_lock) |
                (hwrite & in_table & locked);

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         cap_write <= 1'b0;
         cap_lock  <= 1'b0;
         cap_idx   <= '0;
      end else if (accept) begin
         cap_write <= hwrite;
         cap_lock  <= is_lock;
         cap_idx   <= haddr[IDX_W+1:2];
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 2'd1;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      unique case (state)
         IDLE, DATA, ERR2: begin
            if (accept) begin
               if (bad) begin
                  state_nx = ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_nx = WAIT;
               end else begin
                  state_nx = DATA;
               end
            end
         end
         WAIT:    state_nx = (wait_cnt == WS_LAST) ? DATA : WAIT;
         ERR1:    state_nx = ERR2;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      hreadyout = ~(state == WAIT || state == ERR1);
      hresp     = (state == ERR1 || state == ERR2);
      hrdata    = 32'h0;
      if (state == DATA && !cap_write) begin
         hrdata = cap_lock ? {30'b0, 1'b0, lock} : bank_rd;
      end
   end

   vec_table_bank #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk         (hclk),
      .rst         (hreset),
      .wr_en       (wr_entry),
      .wr_idx      (cap_idx),
      .wr_data     (hwdata),
      .clr_all     (clr_all),
      .rd_idx      (cap_idx),
      .default_vec (default_vec),
      .rd_data     (bank_rd)
   );

endmodule

// File: tb/tb_vec_table_ahb.sv
// Scoreboard bench for vec_table_ahb with two data-phase wait states.
// Expectations follow VEC_TABLE_LOCK_EN when it is defined.
module tb_vec_table_ahb;

   localparam int NI = 16;
   localparam int NE = 16 + NI;
   localparam int WS = 2;
   localparam logic [2:0] WORD = 3'b010;

   logic             hclk = 1'b0;
   logic             hreset = 1'b1;
   logic             hsel = 1'b0;
   logic [11:0]      haddr = '0;
   logic [1:0]       htrans = '0;
   logic [2:0]       hsize = WORD;
   logic             hwrite = 1'b0;
   logic [31:0]      hwdata = '0;
   logic             hreadyin;
   logic             force_nrdy = 1'b0;
   logic [32*NE-1:0] dv;
   logic [31:0]      hrdata;
   logic             hreadyout;
   logic             hresp;

   always #5 hclk = ~hclk;

   assign hreadyin = hreadyout & ~force_nrdy;

   vec_table_ahb #(
      .NUM_IRQ     (NI),
      .WAIT_STATES (WS),
      .ADDR_WIDTH  (12)
   ) u_dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .hsel        (hsel),
      .haddr       (haddr),
      .htrans      (htrans),
      .hsize       (hsize),
      .hwrite      (hwrite),
      .hwdata      (hwdata),
      .hreadyin    (hreadyin),
      .default_vec (dv),
      .hrdata      (hrdata),
      .hreadyout   (hreadyout),
      .hresp       (hresp)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    pend = 0;
   int    stalls = 0;
   logic  first_resp = 1'b0;
   exp_t  e;
   string nm;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   always @(negedge hclk) begin
      if (hreset) begin
         pend = 0;
      end else begin
         if (pend) begin
            if (!hreadyout) begin
               stalls++;
               if (stalls == 1) first_resp = hresp;
            end else begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_completion: got 1 want 0");
               end else begin
                  e  = exp_q.pop_front();
                  nm = name_q.pop_front();
                  check({nm, " hresp"}, 32'(hresp), 32'(e.err));
                  check({nm, " stalls"}, 32'(stalls),
                        e.err ? 32'd1 : 32'(WS));
                  if (e.err) check({nm, " err1_hresp"}, 32'(first_resp), 32'd1);
                  check({nm, " hrdata"}, hrdata, e.data);
               end
               pend = 0;
            end
         end
         if (hreadyout && hreadyin && hsel && htrans[1]) begin
            pend   = 1;
            stalls = 0;
         end
      end
   end

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   task automatic issue(input logic wr, input logic [11:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input logic x_err, input logic [31:0] x_rd,
                        input string name);
      int n = 0;
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hsize  = sz;
      hwrite = wr;
      exp_q.push_back('{err: x_err, data: x_rd});
      name_q.push_back(name);
      @(negedge hclk);
      while (!(hreadyout && hreadyin)) begin
         n++;
         if (n > 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: got 0 want 1", name);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            bus_idle();
            return;
         end
         @(negedge hclk);
      end
      @(posedge hclk);
      #1;
      hwdata = wd;
      bus_idle();
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] want,
                     input string name);
      issue(1'b0, a, WORD, 32'h0, 1'b0, want, name);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d,
                     input string name);
      issue(1'b1, a, WORD, d, 1'b0, 32'h0, name);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend) && n < 40) begin
         @(posedge hclk);
         #2;
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NE; i++) dv[32*i +: 32] = 32'h100 + 32'(i);
      bus_idle();
      hreset = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      check("rst_hreadyout", 32'(hreadyout), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_hrdata", hrdata, 32'h0);
      hreset = 1'b0;
      @(posedge hclk);
      #1;

      rd(12'h004, 32'h0000_0101, "rd_e1");
      wr(12'h040, 32'hDEAD_BEEF, "wr_e16");
      rd(12'h040, 32'hDEAD_BEEF, "rd_e16_b2b");
      rd(12'h044, 32'h0000_0111, "rd_e17");
      issue(1'b0, 12'h000, 3'b001, 32'h0, 1'b1, 32'h0, "err_hsize");
      issue(1'b0, 12'h402, WORD, 32'h0, 1'b1, 32'h0, "err_misalign");
      issue(1'b0, 12'h080, WORD, 32'h0, 1'b1, 32'h0, "err_range_rd");
      issue(1'b1, 12'h080, WORD, 32'h77, 1'b1, 32'h0, "err_range_wr");
      wr(12'h07C, 32'h1234_5678, "wr_e31");
      rd(12'h07C, 32'h1234_5678, "rd_e31");
      rd(12'h000, 32'h0000_0100, "rd_e0");
      rd(12'hFFC, 32'h0, "rd_lock0");
      drain();

      force_nrdy = 1'b1;
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = 12'h004;
      hsize  = WORD;
      hwrite = 1'b1;
      hwdata = 32'hBAD0_BAD0;
      repeat (3) begin
         @(negedge hclk);
         check("nrdy_no_accept", 32'(hreadyout), 32'd1);
      end
      @(posedge hclk);
      #1;
      bus_idle();
      force_nrdy = 1'b0;
      rd(12'h004, 32'h0000_0101, "nrdy_e1_kept");

      wr(12'hFFC, 32'h2, "wr_clear");
      rd(12'h040, 32'h0000_0110, "clr_e16");
      rd(12'h07C, 32'h0000_011F, "clr_e31");

      wr(12'h040, 32'hDEAD_BEEF, "rewr_e16");
      wr(12'hFFC, 32'h1, "wr_lock");
`ifdef VEC_TABLE_LOCK_EN
      issue(1'b1, 12'h040, WORD, 32'hCAFE_F00D, 1'b1, 32'h0, "wr_locked");
      rd(12'h040, 32'hDEAD_BEEF, "locked_e16");
      rd(12'hFFC, 32'h1, "rd_lock1");
      wr(12'hFFC, 32'h2, "clr_locked");
      rd(12'h040, 32'hDEAD_BEEF, "locked_keep");
`else
      wr(12'h040, 32'hCAFE_F00D, "wr_unlocked");
      rd(12'h040, 32'hCAFE_F00D, "unlocked_e16");
      rd(12'hFFC, 32'h0, "rd_lock_off");
      wr(12'hFFC, 32'h2, "clr_unlocked");
      rd(12'h040, 32'h0000_0110, "cleared_e16");
`endif
      drain();

      wr(12'h040, 32'h0BAD_F00D, "pre_rst_e16");
      wr(12'h048, 32'h55AA_55AA, "wr_abort");
      hreset = 1'b1;
      exp_q.delete();
      name_q.delete();
      #1;
      check("abort_hreadyout", 32'(hreadyout), 32'd1);
      check("abort_hresp", 32'(hresp), 32'd0);
      check("abort_hrdata", hrdata, 32'h0);
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(posedge hclk);
      #1;
      rd(12'h048, 32'h0000_0112, "abort_e18");
      rd(12'h040, 32'h0000_0110, "rst_valid_e16");
      rd(12'hFFC, 32'h0, "rst_lock");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
